// File: rtl/frame_read_scheduler.sv
// Vsync-triggered frame reader: issues fixed-length Avalon-MM burst reads into the video stream FIFO.
// Optional macro LINE_STRIDE_EN adds a line_stride input (bytes between line starts).
module frame_read_scheduler #(
  parameter int H_PIXELS   = 960,
  parameter int V_LINES    = 540,
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 512,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vs_toggle,
  input  logic              dma_start,
  input  logic              dma_cont_en,
  input  logic [ADDR_W-1:0] frame_ptr,
`ifdef LINE_STRIDE_EN
  input  logic [ADDR_W-1:0] line_stride,
`endif
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic [7:0]        avm_burstcount,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic [9:0]        fifo_wrusedw,
  output logic              fifo_wr_en,
  output logic [23:0]       fifo_wr_data,
  output logic              fifo_flush,
  output logic              dma_busy,
  output logic              dma_done,
  output logic              overrun,
  input  logic              overrun_clr
);

  localparam int BURSTS_PER_LINE = H_PIXELS / BURST_LEN;
  localparam int LINE_W = $clog2(V_LINES + 1);
  localparam int BIL_W  = $clog2(BURSTS_PER_LINE + 1);
  localparam int BEAT_W = $clog2(BURST_LEN + 1);
  localparam logic [LINE_W-1:0] LAST_LINE   = LINE_W'(V_LINES - 1);
  localparam logic [BIL_W-1:0]  LAST_BIL    = BIL_W'(BURSTS_PER_LINE - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * 4);

  typedef enum logic [1:0] {IDLE, ISSUE, DATA} state_t;

  state_t              state_reg, state_next;
  logic                armed_reg, armed_next;
  logic                restart_pending_reg, restart_pending_next;
  logic [ADDR_W-1:0]   line_base_reg, line_base_next;
  logic [ADDR_W-1:0]   burst_off_reg, burst_off_next;
  logic [LINE_W-1:0]   line_reg, line_next;
  logic [BIL_W-1:0]    bil_reg, bil_next;
  logic [BEAT_W-1:0]   beat_reg, beat_next;
  logic                avm_read_reg, avm_read_next;
  logic [ADDR_W-1:0]   avm_address_reg, avm_address_next;
  logic                fifo_wr_en_reg, fifo_wr_en_next;
  logic [23:0]         fifo_wr_data_reg, fifo_wr_data_next;
  logic                fifo_flush_reg, fifo_flush_next;
  logic                dma_done_reg, dma_done_next;
  logic                overrun_reg, overrun_next;

  logic [2:0]          vs_pipe_reg;
  logic                vs_evt;
  logic                space_ok;
  logic                start_frame;
  logic                overrun_set;
  logic                abort_burst;
  logic                last_burst;
  logic [ADDR_W-1:0]   stride_cur;
  logic                unused_bits;

  assign unused_bits = ^avm_readdata[31:24];

  // Two synchronizer flops plus one delayed copy for edge detection.
  assign vs_evt = vs_pipe_reg[1] ^ vs_pipe_reg[2];

  // Free space test: FIFO_DEPTH - used >= BURST_LEN, done without going negative.
  assign space_ok = ({22'd0, fifo_wrusedw} + 32'(BURST_LEN)) <= 32'(FIFO_DEPTH);

`ifdef LINE_STRIDE_EN
  logic [ADDR_W-1:0] stride_reg;
  always_ff @(posedge clk) begin
    if (reset) begin
      stride_reg <= '0;
    end else if (start_frame) begin
      stride_reg <= line_stride;
    end
  end
  assign stride_cur = stride_reg;
`else
  assign stride_cur = ADDR_W'(H_PIXELS * 4);
`endif

  always_comb begin
    state_next           = state_reg;
    restart_pending_next = restart_pending_reg;
    line_base_next       = line_base_reg;
    burst_off_next       = burst_off_reg;
    line_next            = line_reg;
    bil_next             = bil_reg;
    beat_next            = beat_reg;
    avm_read_next        = avm_read_reg;
    avm_address_next     = avm_address_reg;
    fifo_wr_en_next      = 1'b0;
    fifo_wr_data_next    = fifo_wr_data_reg;
    fifo_flush_next      = 1'b0;
    dma_done_next        = 1'b0;
    start_frame          = 1'b0;
    overrun_set          = 1'b0;
    abort_burst          = restart_pending_reg | vs_evt;
    last_burst           = (line_reg == LAST_LINE) && (bil_reg == LAST_BIL);

    case (state_reg)
      IDLE: begin
        if (vs_evt && (armed_reg || dma_cont_en)) begin
          start_frame = 1'b1;
        end
      end

      ISSUE: begin
        overrun_set = vs_evt;
        if (avm_read_reg) begin
          if (!avm_waitrequest) begin
            avm_read_next = 1'b0;
            beat_next     = '0;
            state_next    = DATA;
            // Accepted in the same cycle as the vsync: drain this burst, then restart.
            if (vs_evt) begin
              restart_pending_next = 1'b1;
            end
          end else if (vs_evt) begin
            start_frame = 1'b1;
          end
        end else if (vs_evt) begin
          start_frame = 1'b1;
        end else if (space_ok) begin
          avm_read_next    = 1'b1;
          avm_address_next = line_base_reg + burst_off_reg;
        end
      end

      DATA: begin
        overrun_set = vs_evt;
        if (vs_evt) begin
          restart_pending_next = 1'b1;
        end
        if (avm_readdatavalid) begin
          fifo_wr_en_next = !abort_burst;
          if (!abort_burst) begin
            fifo_wr_data_next = avm_readdata[23:0];
          end
          beat_next = beat_reg + 1'b1;
          if (beat_reg == LAST_BEAT) begin
            if (abort_burst) begin
              start_frame = 1'b1;
            end else begin
              if (bil_reg == LAST_BIL) begin
                bil_next       = '0;
                burst_off_next = '0;
                line_next      = line_reg + 1'b1;
                line_base_next = line_base_reg + stride_cur;
              end else begin
                bil_next       = bil_reg + 1'b1;
                burst_off_next = burst_off_reg + BURST_BYTES;
              end
              if (last_burst) begin
                dma_done_next = 1'b1;
                state_next    = IDLE;
              end else begin
                state_next = ISSUE;
              end
            end
          end
        end
      end

      default: state_next = IDLE;
    endcase

    // Frame (re)start: shared by the idle trigger and both overrun restart paths.
    if (start_frame) begin
      state_next           = ISSUE;
      restart_pending_next = 1'b0;
      line_base_next       = frame_ptr;
      burst_off_next       = '0;
      line_next            = '0;
      bil_next             = '0;
      beat_next            = '0;
      avm_read_next        = 1'b0;
      fifo_flush_next      = 1'b1;
    end

    armed_next = start_frame ? (dma_start | dma_cont_en)
                             : (armed_reg | dma_start | dma_cont_en);

    if (overrun_set) begin
      overrun_next = 1'b1;
    end else if (overrun_clr) begin
      overrun_next = 1'b0;
    end else begin
      overrun_next = overrun_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vs_pipe_reg         <= '0;
      state_reg           <= IDLE;
      armed_reg           <= 1'b0;
      restart_pending_reg <= 1'b0;
      line_base_reg       <= '0;
      burst_off_reg       <= '0;
      line_reg            <= '0;
      bil_reg             <= '0;
      beat_reg            <= '0;
      avm_read_reg        <= 1'b0;
      avm_address_reg     <= '0;
      fifo_wr_en_reg      <= 1'b0;
      fifo_wr_data_reg    <= '0;
      fifo_flush_reg      <= 1'b0;
      dma_done_reg        <= 1'b0;
      overrun_reg         <= 1'b0;
    end else begin
      vs_pipe_reg         <= {vs_pipe_reg[1:0], vs_toggle};
      state_reg           <= state_next;
      armed_reg           <= armed_next;
      restart_pending_reg <= restart_pending_next;
      line_base_reg       <= line_base_next;
      burst_off_reg       <= burst_off_next;
      line_reg            <= line_next;
      bil_reg             <= bil_next;
      beat_reg            <= beat_next;
      avm_read_reg        <= avm_read_next;
      avm_address_reg     <= avm_address_next;
      fifo_wr_en_reg      <= fifo_wr_en_next;
      fifo_wr_data_reg    <= fifo_wr_data_next;
      fifo_flush_reg      <= fifo_flush_next;
      dma_done_reg        <= dma_done_next;
      overrun_reg         <= overrun_next;
    end
  end

  assign avm_address    = avm_address_reg;
  assign avm_read       = avm_read_reg;
  assign avm_burstcount = 8'(BURST_LEN);
  assign fifo_wr_en     = fifo_wr_en_reg;
  assign fifo_wr_data   = fifo_wr_data_reg;
  assign fifo_flush     = fifo_flush_reg;
  assign dma_busy       = (state_reg != IDLE);
  assign dma_done       = dma_done_reg;
  assign overrun        = overrun_reg;

endmodule

// File: tb/tb_frame_read_scheduler.sv
// Bench for frame_read_scheduler: reduced frame, Avalon slave model, frame-level reference model.
`timescale 1ns/1ps
module tb_frame_read_scheduler;
  localparam int HP = 32, VL = 2, BL = 16, FD = 512, AW = 32;
  localparam int BURSTS = HP * VL / BL;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          vs_toggle = 1'b0;
  logic          dma_start = 1'b0;
  logic          dma_cont_en = 1'b0;
  logic [AW-1:0] frame_ptr = '0;
  logic [AW-1:0] avm_address;
  logic          avm_read;
  logic [7:0]    avm_burstcount;
  logic          avm_waitrequest = 1'b0;
  logic [31:0]   avm_readdata = '0;
  logic          avm_readdatavalid = 1'b0;
  logic [9:0]    fifo_wrusedw = '0;
  logic          fifo_wr_en;
  logic [23:0]   fifo_wr_data;
  logic          fifo_flush;
  logic          dma_busy;
  logic          dma_done;
  logic          overrun;
  logic          overrun_clr = 1'b0;

  frame_read_scheduler #(.H_PIXELS(HP), .V_LINES(VL), .BURST_LEN(BL), .FIFO_DEPTH(FD), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .vs_toggle(vs_toggle), .dma_start(dma_start),
    .dma_cont_en(dma_cont_en), .frame_ptr(frame_ptr), .avm_address(avm_address),
    .avm_read(avm_read), .avm_burstcount(avm_burstcount), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .fifo_wrusedw(fifo_wrusedw), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .fifo_flush(fifo_flush), .dma_busy(dma_busy), .dma_done(dma_done), .overrun(overrun),
    .overrun_clr(overrun_clr)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // Reference model: frame progress as burst index / beats left.
  bit          m_valid = 0;
  bit [2:0]    m_hist;
  bit          m_active, m_armed, m_req, m_drop, m_ovr;
  int          m_k, m_left;
  logic [31:0] m_base, m_addr;
  bit          e_flush, e_done, e_wr;
  logic [23:0] e_data;

  always @(posedge clk) begin
    bit evt, start, abort, ovr_set;
    if (reset) begin
      m_valid = 1; m_hist = '0; m_active = 0; m_armed = 0; m_req = 0; m_drop = 0;
      m_ovr = 0; m_k = 0; m_left = 0; e_flush = 0; e_done = 0; e_wr = 0;
    end else begin
      evt = m_hist[1] ^ m_hist[2];
      m_hist = {m_hist[1:0], vs_toggle};
      e_flush = 0; e_done = 0; e_wr = 0; start = 0;
      ovr_set = evt && m_active;
      if (!m_active) begin
        if (evt && (m_armed || dma_cont_en)) start = 1;
      end else if (m_left == 0) begin
        if (m_req && !avm_waitrequest) begin
          m_req = 0; m_left = BL;
          if (evt) m_drop = 1;
        end else if (evt) begin
          start = 1;
        end else if (!m_req && (int'(fifo_wrusedw) <= FD - BL)) begin
          m_req = 1; m_addr = m_base + 32'(m_k * BL * 4);
        end
      end else begin
        abort = m_drop || evt;
        if (evt) m_drop = 1;
        if (avm_readdatavalid) begin
          if (!abort) begin e_wr = 1; e_data = avm_readdata[23:0]; end
          m_left--;
          if (m_left == 0) begin
            if (abort) start = 1;
            else begin
              m_k++;
              if (m_k == BURSTS) begin e_done = 1; m_active = 0; end
            end
          end
        end
      end
      if (start) begin
        m_active = 1; m_base = frame_ptr; m_k = 0; m_req = 0; m_left = 0; m_drop = 0;
        e_flush = 1; m_armed = dma_start || dma_cont_en;
      end else begin
        m_armed = m_armed || dma_start || dma_cont_en;
      end
      if (ovr_set) m_ovr = 1;
      else if (overrun_clr) m_ovr = 0;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("avm_read", 32'(avm_read), 32'(m_req));
      if (m_req) check("avm_address", avm_address, m_addr);
      check("fifo_wr_en", 32'(fifo_wr_en), 32'(e_wr));
      if (e_wr) check("fifo_wr_data", 32'(fifo_wr_data), 32'(e_data));
      check("fifo_flush", 32'(fifo_flush), 32'(e_flush));
      check("dma_done", 32'(dma_done), 32'(e_done));
      check("dma_busy", 32'(dma_busy), 32'(m_active));
      check("overrun", 32'(overrun), 32'(m_ovr));
    end
  end

  // Avalon slave: accepts bursts, returns BL random beats each.
  bit            rand_wait = 0;
  int            rdv_pct = 100;
  int            force_wait_n = 0;
  int            beat_budget = -1;
  logic [31:0]   beat_q[$];
  logic [31:0]   acc_log[$];
  int            rdv_total = 0;
  int            stall_cnt = 0;
  bit            stall_bad = 0;
  bit            stall_run = 0;
  logic [31:0]   stall_addr = '0;
  bit            prev_rd = 0, prev_wt = 0;
  logic [31:0]   prev_a = '0;

  always @(negedge clk) begin
    if (prev_rd && prev_wt) begin
      stall_cnt++;
      if (stall_run && prev_a != stall_addr) stall_bad = 1;
      stall_addr = prev_a; stall_run = 1;
    end else begin
      stall_run = 0;
    end
    if (prev_rd && !prev_wt) begin
      acc_log.push_back(prev_a);
      for (int b = 0; b < BL; b++) beat_q.push_back($urandom);
    end
    if (reset) beat_q.delete();
    if (beat_q.size() > 0 && beat_budget != 0 && $urandom_range(99) < rdv_pct) begin
      avm_readdatavalid = 1'b1;
      avm_readdata = beat_q.pop_front();
      rdv_total++;
      if (beat_budget > 0) beat_budget--;
    end else begin
      avm_readdatavalid = 1'b0;
      avm_readdata = $urandom;
    end
    if (force_wait_n > 0 && avm_read) begin
      avm_waitrequest = 1'b1; force_wait_n--;
    end else if (rand_wait) begin
      avm_waitrequest = ($urandom_range(3) == 0);
    end else begin
      avm_waitrequest = 1'b0;
    end
    prev_rd = avm_read; prev_wt = avm_waitrequest; prev_a = avm_address;
  end

  int wr_count = 0, done_count = 0, flush_count = 0, wr_at_done = 0;
  bit wr_en_at_done = 0;
  always @(negedge clk) begin
    if (fifo_wr_en) wr_count++;
    if (fifo_flush) flush_count++;
    if (dma_done) begin done_count++; wr_at_done = wr_count; wr_en_at_done = fifo_wr_en; end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_done(input int d0, input string name);
    for (int i = 0; i < 3000 && done_count == d0; i++) tick();
    check(name, 32'(done_count != d0), 32'd1);
    tick(4);
  endtask

  task automatic wait_acc(input int a0, input string name);
    for (int i = 0; i < 1000 && acc_log.size() <= a0; i++) tick();
    check(name, 32'(acc_log.size() > a0), 32'd1);
  endtask

  task automatic start_pulse();
    dma_start = 1'b1; tick(); dma_start = 1'b0; tick();
  endtask

  initial begin
    int a0, w0, d0, f0, s0, r0, w1, n, rd_hi;
    logic [31:0] ptrs[3];
    ptrs[0] = 32'h4000_0000; ptrs[1] = 32'h4100_0000; ptrs[2] = 32'h4200_0000;

    tick(4); reset = 1'b0; tick();
    check("reset_avm_read", 32'(avm_read), 0);
    check("reset_avm_address", avm_address, 0);
    check("reset_busy", 32'(dma_busy), 0);
    check("reset_overrun", 32'(overrun), 0);
    check("reset_flush_done", {fifo_flush, dma_done, fifo_wr_en}, 0);

    // Basic frame: four bursts, 64 writes, one done.
    frame_ptr = 32'h3000_0000;
    start_pulse();
    a0 = acc_log.size(); w0 = wr_count; d0 = done_count;
    vs_toggle = ~vs_toggle;
    n = 0;
    for (int i = 1; i <= 10; i++) begin tick(); if (fifo_flush) begin n = i; break; end end
    check("flush_latency", n, 3);
    wait_done(d0, "frame1_done_timeout");
    tick(20);
    check("frame1_bursts", acc_log.size() - a0, 4);
    for (int i = 0; i < 4; i++)
      if (acc_log.size() > a0 + i) check("frame1_addr", acc_log[a0 + i], 32'h3000_0000 + 32'(i * 64));
    check("frame1_writes", wr_count - w0, 64);
    check("frame1_dones", done_count - d0, 1);
    check("done_on_64th", wr_at_done - w0, 64);
    check("done_with_wr", 32'(wr_en_at_done), 1);

    // FIFO space throttle at 497 / 496.
    frame_ptr = 32'h1000_0000; fifo_wrusedw = 10'd497;
    start_pulse();
    d0 = done_count;
    vs_toggle = ~vs_toggle;
    tick(4);
    rd_hi = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (avm_read) rd_hi++; end
    check("throttle_read_low", rd_hi, 0);
    check("throttle_busy", 32'(dma_busy), 1);
    fifo_wrusedw = 10'd496; tick();
    check("throttle_release_read", 32'(avm_read), 1);
    check("throttle_release_addr", avm_address, 32'h1000_0000);
    wait_done(d0, "frame2_done_timeout");
    fifo_wrusedw = 10'd0;

    // Five-cycle waitrequest stall on burst 1.
    frame_ptr = 32'h2000_0100; rdv_pct = 60;
    start_pulse();
    a0 = acc_log.size(); s0 = stall_cnt; d0 = done_count;
    vs_toggle = ~vs_toggle;
    wait_acc(a0, "stall_first_accept");
    force_wait_n = 5;
    wait_done(d0, "frame3_done_timeout");
    check("stall_cycles", stall_cnt - s0, 5);
    check("stall_addr_stable", 32'(stall_bad), 0);
    check("stall_bursts", acc_log.size() - a0, 4);
    if (acc_log.size() > a0 + 1) check("stall_burst1_addr", acc_log[a0 + 1], 32'h2000_0140);
    rdv_pct = 100;

    // Continuous mode, pointer changes mid-frame apply only to the next frame.
    dma_cont_en = 1'b1; d0 = done_count;
    for (int f = 0; f < 3; f++) begin
      frame_ptr = ptrs[f]; a0 = acc_log.size(); w0 = done_count;
      vs_toggle = ~vs_toggle; tick(5);
      frame_ptr = 32'hDEAD_0000;
      wait_done(w0, "cont_done_timeout");
      if (acc_log.size() > a0 + 3) begin
        check("cont_first_addr", acc_log[a0], ptrs[f]);
        check("cont_last_addr", acc_log[a0 + 3], ptrs[f] + 32'h0C0);
      end else check("cont_burst_count", acc_log.size() - a0, 4);
    end
    check("cont_dones", done_count - d0, 3);
    dma_cont_en = 1'b0; tick(4);

    // Overrun mid-burst after 7 beats.
    frame_ptr = 32'h5000_0000; beat_budget = 7;
    start_pulse();
    w0 = wr_count; d0 = done_count; f0 = flush_count;
    vs_toggle = ~vs_toggle;
    for (int i = 0; i < 400 && (wr_count - w0) < 7; i++) tick();
    tick(2);
    check("ovr_pre_writes", wr_count - w0, 7);
    check("ovr_pre_flag", 32'(overrun), 0);
    frame_ptr = 32'h6000_0000;
    vs_toggle = ~vs_toggle; tick(5);
    check("ovr_flag_set", 32'(overrun), 1);
    w1 = wr_count; r0 = rdv_total; a0 = acc_log.size();
    beat_budget = -1;
    for (int i = 0; i < 200 && (rdv_total - r0) < 9; i++) tick();
    tick(2);
    check("ovr_remaining_beats", rdv_total - r0, 9);
    check("ovr_suppressed_writes", wr_count - w1, 0);
    wait_acc(a0, "ovr_restart_accept");
    if (acc_log.size() > a0) check("ovr_restart_addr", acc_log[a0], 32'h6000_0000);
    check("ovr_flushes", flush_count - f0, 2);
    check("ovr_still_set", 32'(overrun), 1);
    overrun_clr = 1'b1; tick(); overrun_clr = 1'b0; tick();
    check("ovr_cleared", 32'(overrun), 0);
    wait_done(d0, "ovr_frame_done_timeout");
    check("ovr_one_done", done_count - d0, 1);

    // Unarmed vsync is ignored.
    a0 = acc_log.size(); rd_hi = 0;
    vs_toggle = ~vs_toggle;
    for (int i = 0; i < 30; i++) begin tick(); if (avm_read || dma_busy) rd_hi++; end
    check("unarmed_idle", rd_hi, 0);
    check("unarmed_no_accept", acc_log.size() - a0, 0);

    // Randomized traffic with a mid-run reset.
    rand_wait = 1; rdv_pct = 70;
    for (int i = 0; i < 5000; i++) begin
      dma_start = ($urandom_range(199) == 0);
      overrun_clr = ($urandom_range(63) == 0);
      if ($urandom_range(299) == 0) dma_cont_en = ~dma_cont_en;
      if ($urandom_range(249) == 0) vs_toggle = ~vs_toggle;
      if ($urandom_range(7) == 0) fifo_wrusedw = 10'($urandom_range(0, 520));
      if ($urandom_range(49) == 0) frame_ptr = $urandom;
      reset = (i >= 2500 && i < 2503);
      tick();
    end
    dma_start = 1'b0; overrun_clr = 1'b0; reset = 1'b0;
    tick(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_read_scheduler.md
Name: frame_read_scheduler

Overview:
- Sequences the DDR3 frame-buffer reads that feed the stream FIFO behind the HDMI sync generator's DMA stream mode.
- On each vertical-sync event it latches the frame pointer and issues fixed-length Avalon-MM burst reads line by line.
- Throttles bursts on FIFO free space, reports busy/done, and flags frame overruns.
- Lives in the CSR clock domain (50 MHz) between the sync generator's control outputs and the memory interconnect.

Parameters:
- H_PIXELS, 960, words (pixels) per line; one 32-bit word per pixel, RGB in [23:0].
- V_LINES, 540, lines per frame.
- BURST_LEN, 16, beats per burst; must divide H_PIXELS.
- FIFO_DEPTH, 512, stream FIFO depth in words.
- ADDR_W, 32, Avalon byte-address width.

Ports:
- clk  in  1  CSR clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- vs_toggle  in  1  vsync toggle from the pixel domain; synchronized internally with 2 flops.
- dma_start  in  1  single-cycle start request.
- dma_cont_en  in  1  continuous mode: restart on every vsync.
- frame_ptr  in  ADDR_W  frame base byte address; sampled only at frame start.
- avm_address  out  ADDR_W  burst byte address.
- avm_read  out  1  read request.
- avm_burstcount  out  8  constant BURST_LEN.
- avm_waitrequest  in  1  Avalon stall.
- avm_readdata  in  32  read data.
- avm_readdatavalid  in  1  read data valid.
- fifo_wrusedw  in  10  FIFO fill level in words.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_wr_data  out  24  pixel to FIFO.
- fifo_flush  out  1  one-cycle FIFO clear pulse.
- dma_busy  out  1  frame transfer in progress.
- dma_done  out  1  one-cycle pulse when the last beat of a frame is written.
- overrun  out  1  sticky flag: a vsync arrived before the frame completed.
- overrun_clr  in  1  clears overrun.

Behaviour:
- Reset values:
  - avm_read=0, avm_address=0, fifo_wr_en=0, fifo_flush=0, dma_busy=0, dma_done=0, overrun=0.
  - State=IDLE, armed=0.
  - Synchronizer flops cleared; a synchronous reset mid-burst drops the request immediately, and the interconnect is reset alongside this block.
- vs_evt: one-cycle pulse when synchronized vs_toggle differs from its delayed copy. Latency is 3 clk from the toggle edge.
- armed is set by dma_start and cleared when a frame starts; dma_cont_en holds it set.
- IDLE:
  - On vs_evt with (armed or dma_cont_en): base<=frame_ptr, burst_idx<=0, beat_cnt<=0, assert fifo_flush for 1 cycle, go to ISSUE.
  - vs_evt without arming is ignored.
- ISSUE:
  - Wait until free = FIFO_DEPTH - fifo_wrusedw >= BURST_LEN.
  - Then drive avm_read=1 and avm_address = base + burst_idx*BURST_LEN*4, holding both while avm_waitrequest=1.
  - On the accept cycle (read & !waitrequest): avm_read<=0, go to DATA.
- DATA:
  - Each avm_readdatavalid: fifo_wr_en=1 with fifo_wr_data=avm_readdata[23:0], same cycle (combinational pass-through of the registered valid is not permitted; register both, giving 1-cycle latency).
  - After BURST_LEN beats: burst_idx+1.
  - If burst_idx was last (V_LINES*H_PIXELS/BURST_LEN - 1): pulse dma_done, go to IDLE. Otherwise go to ISSUE.
- One burst outstanding at most. Free space is computed in ISSUE only, so it can never overflow the FIFO.
- dma_busy=1 in ISSUE and DATA.
- vs_evt while busy (overrun):
  - Set overrun and set restart_pending.
  - If in ISSUE with the request not yet accepted: drop avm_read, restart immediately as from IDLE.
  - If in DATA: finish receiving the remaining beats with fifo_wr_en suppressed, then restart. fifo_flush pulses on restart.
  - No dma_done for the aborted frame.
- overrun_clr and an overrun set on the same cycle: set wins.
- dma_start while busy: sets armed only; has no effect on the current frame.
- Address arithmetic is modulo 2^ADDR_W; wrap is not detected.

Optional Feature:
- LINE_STRIDE_EN.
- Defined:
  - Adds input line_stride (ADDR_W, bytes), sampled with frame_ptr at frame start.
  - Address = base + line*stride + (burst_in_line*BURST_LEN*4), tracked with line and burst-in-line counters (no multipliers; accumulate).
- Undefined: lines are contiguous (stride = H_PIXELS*4), port absent.

Test Plan:
- Reduced size (H_PIXELS=32, V_LINES=2, BURST_LEN=16), frame_ptr=0x30000000, dma_start then vs toggle → exactly 4 bursts at 0x30000000, 0x30000040, 0x30000080, 0x300000C0; 64 fifo_wr_en; fifo_flush 3 clk after the toggle; one dma_done on the 64th write.
- Hold fifo_wrusedw=497 → avm_read stays low; drop to 496 → burst issued next cycle.
- avm_waitrequest high 5 cycles on burst 1 → address/read stable across all 5 cycles; exactly one accept.
- dma_cont_en=1, three vs toggles with frame completing between each → three dma_done pulses; frame_ptr change between frames takes effect only on the next frame.
- vs toggle mid-DATA after 7 of 16 beats → 9 remaining beats arrive with no fifo_wr_en; overrun=1; restart at the new frame_ptr with fifo_flush; overrun_clr clears it.
- vs toggle with no dma_start and dma_cont_en=0 → no avm_read, dma_busy stays 0.
